// File: rtl/ptor_pkg.sv
// rtl/ptor_pkg.sv - shared state type and parameter defaults for ptor_arbiter
package ptor_pkg;

  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker
// A lone request wins outright; on a tie the requester not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  assign winner = req1 & (~req0 | ~last);

endmodule

// File: rtl/ptor_arbiter.sv
// rtl/ptor_arbiter.sv - two-requester front end for a shared polar-to-rect converter
// Round-robin grant, one conversion in flight, bounded wait with timeout error.
module ptor_arbiter
  import ptor_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] A0,
  input  logic [DW-1:0] A1,
  input  logic [DW-1:0] Ang0,
  input  logic [DW-1:0] Ang1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] x_out,
  output logic [DW-1:0] y_out,
  output logic          err,
  output logic          busy,
  output logic          conv_start,
  output logic [DW-1:0] conv_A,
  output logic [DW-1:0] conv_Angle,
  input  logic          conv_done,
  input  logic [DW-1:0] conv_x,
  input  logic [DW-1:0] conv_y
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       last;
  logic       served;
  logic       win;
  logic       any_req;

  assign any_req = req0 | req1;

  rr_arb2 u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (win)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (conv_done || cnt == CNT_LAST) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // last resets to 1 so requester 0 takes the first tie
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt        <= '0;
      last       <= 1'b1;
      served     <= 1'b0;
      conv_A     <= '0;
      conv_Angle <= '0;
      x_out      <= '0;
      y_out      <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            served     <= win;
            conv_A     <= win ? A1 : A0;
            conv_Angle <= win ? Ang1 : Ang0;
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          if (conv_done) begin
            x_out <= conv_x;
            y_out <= conv_y;
            err   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            x_out <= '0;
            y_out <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: last <= served;
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign conv_start = (state == S_START);
  assign gnt0       = (state == S_START) && !served;
  assign gnt1       = (state == S_START) &&  served;
  assign done0      = (state == S_RESP)  && !served;
  assign done1      = (state == S_RESP)  &&  served;

endmodule

// File: tb/tb_ptor_arbiter.sv
// tb/tb_ptor_arbiter.sv - self-checking bench for ptor_arbiter
module tb_ptor_arbiter;

  localparam int DW = 8;
  localparam int TO = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req0, req1;
  logic [DW-1:0] A0, A1, Ang0, Ang1;
  logic          gnt0, gnt1, done0, done1;
  logic [DW-1:0] x_out, y_out;
  logic          err, busy, conv_start;
  logic [DW-1:0] conv_A, conv_Angle;
  logic          conv_done;
  logic [DW-1:0] conv_x, conv_y;

  ptor_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1),
    .A0(A0), .A1(A1), .Ang0(Ang0), .Ang1(Ang1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .x_out(x_out), .y_out(y_out), .err(err), .busy(busy),
    .conv_start(conv_start), .conv_A(conv_A), .conv_Angle(conv_Angle),
    .conv_done(conv_done), .conv_x(conv_x), .conv_y(conv_y)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Converter stand-in: conv_done arrives in WAIT cycle number cv_lat (0 = never)
  int            cv_lat  = 0;
  int            cv_cnt  = 0;
  bit            cv_late = 0;
  logic [DW-1:0] cv_x = '0, cv_y = '0;

  always @(posedge CLK) begin
    #2;
    conv_done = 1'b0;
    if (!RST) cv_cnt = 0;
    if (cv_late) begin
      conv_done = 1'b1;
      cv_late   = 0;
    end
    if (cv_cnt > 0) begin
      if (cv_cnt == cv_lat) begin
        conv_done = 1'b1;
        conv_x    = cv_x;
        conv_y    = cv_y;
        cv_cnt    = 0;
      end else begin
        cv_cnt++;
      end
    end
    if (conv_start) cv_cnt = (cv_lat > 0) ? 1 : 0;
  end

  // Transaction-level reference: grant cycle, done cycle, result per transaction
  int            cyc = 0;
  bit            m_active = 0;
  int            m_gcyc = -1, m_dcyc = -1;
  bit            m_who = 0, m_last = 1, m_err = 0;
  logic [DW-1:0] m_x = '0, m_y = '0, m_a = '0, m_ang = '0;

  always @(posedge CLK) begin
    if (!RST) begin
      m_active = 0; m_last = 1; m_err = 0;
      m_x = '0; m_y = '0; m_a = '0; m_ang = '0;
      m_gcyc = -1; m_dcyc = -1;
    end else begin
      if (m_active && m_dcyc < 0 && cyc > m_gcyc && cyc <= m_gcyc + TO) begin
        if (conv_done) begin
          m_dcyc = cyc + 1; m_x = conv_x; m_y = conv_y; m_err = 0;
        end else if (cyc == m_gcyc + TO) begin
          m_dcyc = cyc + 1; m_x = '0; m_y = '0; m_err = 1;
        end
      end
      if (m_active && cyc == m_dcyc) begin
        m_active = 0;
        m_last   = m_who;
      end else if (!m_active && (req0 || req1)) begin
        m_who    = (req0 && req1) ? !m_last : req1;
        m_a      = m_who ? A1 : A0;
        m_ang    = m_who ? Ang1 : Ang0;
        m_active = 1;
        m_gcyc   = cyc + 1;
        m_dcyc   = -1;
      end
    end
    cyc++;
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      chk("gnt0",       gnt0,       m_active && cyc == m_gcyc && !m_who);
      chk("gnt1",       gnt1,       m_active && cyc == m_gcyc &&  m_who);
      chk("conv_start", conv_start, m_active && cyc == m_gcyc);
      chk("done0",      done0,      m_active && cyc == m_dcyc && !m_who);
      chk("done1",      done1,      m_active && cyc == m_dcyc &&  m_who);
      chk("busy",       busy,       m_active);
      chk("x_out",      x_out,      m_x);
      chk("y_out",      y_out,      m_y);
      chk("err",        err,        m_err);
      if (m_active) begin
        chk("conv_A",     conv_A,     m_a);
        chk("conv_Angle", conv_Angle, m_ang);
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(input string nm, output int who, output int c);
    who = -1;
    c   = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        c   = cyc;
        break;
      end
    end
    if (who < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no gnt within 30 cycles", nm);
    end
  endtask

  task automatic wait_done(input string nm, output int who, output int c);
    who = -1;
    c   = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done0 || done1) begin
        who = done1 ? 1 : 0;
        c   = cyc;
        break;
      end
    end
    if (who < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within 30 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int who, g, d, g1, d0;
    RST = 1'b0; req0 = 0; req1 = 0;
    A0 = '0; A1 = '0; Ang0 = '0; Ang1 = '0;
    conv_done = 0; conv_x = '0; conv_y = '0;
    repeat (3) tick();
    RST = 1'b1;
    chk("rst_busy",  busy,   0);
    chk("rst_x",     x_out,  0);
    chk("rst_convA", conv_A, 0);
    chk("rst_err",   err,    0);

    // single request, done 5 cycles after gnt
    A0 = 8'd4; Ang0 = 8'd30; cv_lat = 4; cv_x = 8'd3; cv_y = 8'd2;
    req0 = 1;
    wait_gnt("t1_gnt", who, g);
    req0 = 0;
    chk("t1_who", who, 0);
    chk("t1_start", conv_start, 1);
    chk("t1_A", conv_A, 4);
    chk("t1_Ang", conv_Angle, 30);
    wait_done("t1_done", who, d);
    chk("t1_lat", d - g, 5);
    chk("t1_x", x_out, 3);
    chk("t1_y", y_out, 2);
    chk("t1_err", err, 0);
    tick();
    chk("t1_idle", busy, 0);

    // tie right after reset: 0 first, then 1 after one IDLE cycle
    RST = 0; tick(); RST = 1;
    A0 = 8'd5; Ang0 = 8'd10; A1 = 8'd8; Ang1 = 8'd90;
    cv_lat = 2; cv_x = 8'd7; cv_y = 8'hFF;
    req0 = 1; req1 = 1;
    wait_gnt("t2_gnt0", who, g);
    req0 = 0;
    chk("t2_first", who, 0);
    wait_done("t2_done0", who, d0);
    wait_gnt("t2_gnt1", who, g1);
    req1 = 0;
    chk("t2_second", who, 1);
    chk("t2_A1", conv_A, 8);
    chk("t2_Ang1", conv_Angle, 90);
    chk("t2_gap", g1 - d0, 2);
    wait_done("t2_done1", who, d);
    chk("t2_y", y_out, 8'hFF);

    // fairness under continuous requests
    cv_lat = 1; A0 = 8'd1; A1 = 8'd2;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      wait_gnt("t3_gnt", who, g);
      chk($sformatf("t3_order%0d", i), who, i % 2);
      wait_done("t3_done", who, d);
    end
    req0 = 0; req1 = 0;
    repeat (2) tick();

    // timeout: converter silent, x/y forced to zero
    A0 = 8'd9; Ang0 = 8'd45; cv_lat = 0;
    conv_x = 8'h55; conv_y = 8'h66;
    req0 = 1;
    wait_gnt("t4_gnt", who, g);
    req0 = 0;
    wait_done("t4_done", who, d);
    chk("t4_lat", d - g, 9);
    chk("t4_err", err, 1);
    chk("t4_x", x_out, 0);
    chk("t4_y", y_out, 0);
    tick();
    chk("t4_idle", busy, 0);

    // conv_done exactly in the timeout cycle wins
    cv_lat = TO; cv_x = 8'h11; cv_y = 8'h22;
    req0 = 1;
    wait_gnt("t5_gnt", who, g);
    req0 = 0;
    wait_done("t5_done", who, d);
    chk("t5_lat", d - g, 9);
    chk("t5_err", err, 0);
    chk("t5_x", x_out, 8'h11);
    chk("t5_y", y_out, 8'h22);

    // reset during WAIT, late conv_done ignored, pointer back to 1
    repeat (2) tick();
    cv_lat = 0; A1 = 8'd3;
    req1 = 1;
    wait_gnt("t6_gnt", who, g);
    req1 = 0;
    chk("t6_who", who, 1);
    repeat (2) tick();
    RST = 0;
    tick();
    RST = 1;
    chk("t6_rst_busy", busy, 0);
    cv_late = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_done", done0 | done1, 0);
      chk("t6_idle", busy, 0);
    end
    cv_lat = 1; A0 = 8'd6; A1 = 8'd7;
    req0 = 1; req1 = 1;
    wait_gnt("t6_tie", who, g);
    req0 = 0; req1 = 0;
    chk("t6_tie_who", who, 0);
    wait_done("t6_done", who, d);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ptor_arbiter.md
PTOR_ARBITER -- requirements
Module: ptor_arbiter

Interface
REQ-001 Parameter DW, default 8: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before a conversion is abandoned; legal range 2..255.
REQ-003 CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-low: it takes effect only at a rising CLK edge while low.
REQ-005 req0, req1  in  1 each  request from requester 0/1; a raised request stays high until its gnt is seen.
REQ-006 A0, A1  in  DW each  magnitude operand of requester 0/1 (unsigned).
REQ-007 Ang0, Ang1  in  DW each  angle operand of requester 0/1 in degrees (unsigned).
REQ-008 gnt0, gnt1  out  1 each  one-cycle acceptance pulse for requester 0/1.
REQ-009 done0, done1  out  1 each  one-cycle completion pulse for requester 0/1.
REQ-010 x_out, y_out  out  DW each  signed rectangular result; valid while done0 or done1 is high.
REQ-011 err  out  1  timeout flag; valid while done0 or done1 is high.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 conv_start  out  1  one-cycle start pulse to the shared polar-to-rectangular converter.
REQ-014 conv_A, conv_Angle  out  DW each  latched operands driven to the converter.
REQ-015 conv_done  in  1  converter completion pulse.
REQ-016 conv_x, conv_y  in  DW each  signed converter results; valid while conv_done is high.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, WAIT and RESP.
REQ-018 IDLE: when at least one req is sampled high, select a winner, latch its operands into conv_A/conv_Angle and go to START; otherwise stay in IDLE.
REQ-019 Arbitration is round-robin: with a single request, that requester wins; with both requests, the requester not served last wins.
REQ-020 START lasts exactly 1 cycle: gntN=1 and conv_start=1 in that cycle, the timeout counter is cleared, and the next state is WAIT.
REQ-021 WAIT: when conv_done=1, capture conv_x/conv_y and go to RESP with err=0.
REQ-022 WAIT timeout: when the counter equals TIMEOUT-1 and conv_done=0, go to RESP with err=1 and x_out=y_out=0.
REQ-023 WAIT otherwise: increment the counter; WAIT therefore lasts at most TIMEOUT cycles.
REQ-024 If conv_done=1 in the timeout cycle, conv_done takes priority and no error is flagged.
REQ-025 RESP lasts exactly 1 cycle: doneN=1 for the served requester, the last-served pointer is updated, and the next state is IDLE.
REQ-026 conv_done outside WAIT SHALL be ignored.
REQ-027 req is not sampled outside IDLE; a requester may re-raise req after its gnt, and that request is served from the next IDLE.
REQ-028 Latency: req sampled at edge E0 gives gnt and conv_start in the cycle after E0; doneN follows the conv_done cycle by exactly 1 cycle.
REQ-029 conv_A/conv_Angle SHALL hold their value from START through RESP; x_out, y_out and err hold their value until the next RESP.

Reset
REQ-030 While RST=0 at a clock edge: state becomes IDLE; gnt*, done*, conv_start, busy and err become 0; x_out, y_out, conv_A, conv_Angle and the counter become 0; the last-served pointer becomes 1, so requester 0 wins the first tie.
REQ-031 Reset during START, WAIT or RESP SHALL abandon the transaction with no done pulse; a late conv_done after reset is ignored.

Structure
REQ-032 Package ptor_pkg SHALL hold the state enumeration, the DW default and the TIMEOUT default.
REQ-033 The two-way round-robin picker SHALL be sub-module rr_arb2 (inputs: req0, req1, last; output: winner index); everything else is in ptor_arbiter.

Verification
REQ-034 Single request. req0, A0=4, Ang0=30; converter model returns conv_done after 3 WAIT cycles with x=3, y=2. Required: gnt0 and conv_start in the same cycle; conv_A=4 and conv_Angle=30; done0 with x_out=3, y_out=2, err=0, 5 cycles after gnt0.
REQ-035 Tie after reset. req0 and req1 both high (A1=8, Ang1=90). Required: requester 0 served first, then requester 1 (conv_A=8) with no extra idle cycle between its RESP and its START.
REQ-036 Fairness. Both requesters continuously re-request for 6 transactions. Required: gnt sequence is 0,1,0,1,0,1.
REQ-037 Timeout. TIMEOUT=8, converter never completes. Required: done0 with err=1 and x_out=y_out=0 exactly 8 WAIT cycles after conv_start; then IDLE.
REQ-038 conv_done in the timeout cycle. Required: err=0 and the results are captured.
REQ-039 Reset mid-transaction. RST=0 for 1 cycle during WAIT, then a late conv_done. Required: no done pulse, busy=0, the FSM stays in IDLE, and the next tie is won by requester 0.
